quad_stream_core: RTL and testbench

QUAD_STREAM_CORE -- requirements
Module: quad_stream_core

---
 rtl/quad_stream_core.sv | 236 +++++++++++++++++++++++
 tb/tb_quad_stream_core.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_stream_core.sv
// Purpose: signed fixed-point multiplier stream with alignment, saturation and an output FIFO.
// Latency: a pair accepted on edge N is written to the FIFO on edge N+3 and is visible right after it.
// Backpressure: in_ready counts FIFO entries plus in-flight stages against DEPTH, so results are never dropped.

module qsc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_vld,
  input  logic [W-1:0]           wr_dat,
  output logic                   rd_vld,
  input  logic                   rd_rdy,
  output logic [W-1:0]           rd_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Writers upstream guarantee a free slot, so a write is never refused.
  assign push   = wr_vld;
  assign pop    = rd_vld && rd_rdy;
  assign rd_vld = (level != '0);
  assign rd_dat = mem[rd_ptr];

  // Storage array; contents are only meaningful below the level count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  // Pointer and level bookkeeping; push+pop together leaves the level unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

module quad_stream_core #(
  parameter int W_IN  = 14,
  parameter int W_OUT = 29,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  a,
  input  logic [W_IN-1:0]  b,
  input  logic [7:0]       num_frac_a,
  input  logic [7:0]       num_frac_b,
  input  logic [7:0]       num_frac_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] c,
  output logic             sat,
  output logic [15:0]      out_count
);
  localparam int PW   = 2 * W_IN;
  localparam int WIDE = PW + W_OUT;
  localparam int LW   = $clog2(DEPTH) + 1;
  localparam int CW   = LW + 1;

  // Right shifts at or beyond the product width collapse to the sign.
  localparam logic [9:0] SH_RZ  = 10'(PW);
  // Any nonzero product shifted left by W_OUT or more cannot fit the result.
  localparam logic [9:0] SH_LOV = 10'(W_OUT);

  localparam logic signed [WIDE-1:0] WIDE_MAX = {1'b0, {(WIDE-1){1'b1}}};
  localparam logic signed [WIDE-1:0] WIDE_MIN = {1'b1, {(WIDE-1){1'b0}}};
  localparam logic signed [WIDE-1:0] OUT_MAX  = {{(WIDE-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [WIDE-1:0] OUT_MIN  = {{(WIDE-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};
  localparam logic [CW-1:0]          DEP_CW   = CW'(DEPTH);

  typedef struct packed {
    logic [PW-1:0] prod;
    logic [7:0]    nfa;
    logic [7:0]    nfb;
    logic [7:0]    nfc;
  } s1_t;

  typedef struct packed {
    logic [W_OUT-1:0] val;
    logic             sat;
  } res_t;

  logic                   run;
  logic                   accept;
  logic signed [PW-1:0]   a_ext;
  logic signed [PW-1:0]   b_ext;
  logic signed [PW-1:0]   prod;

  logic                   s1_vld;
  s1_t                    s1_dat;
  logic                   s2_vld;
  logic signed [WIDE-1:0] s2_dat;
  logic                   s3_vld;
  res_t                   s3_dat;

  logic [9:0]             sh_raw;
  logic [9:0]             sh_mag;
  logic                   p_neg;
  logic                   p_zero;
  logic signed [WIDE-1:0] p_ext;
  logic signed [WIDE-1:0] aligned;
  res_t                   res_nxt;

  logic                   head_vld;
  res_t                   head_dat;
  logic [LW-1:0]          fifo_level;
  logic [CW-1:0]          occupancy;

  // Slots in use: everything in the pipeline already has a FIFO entry reserved.
  // Accept-to-pop spans five edges, so full one-per-cycle rate needs DEPTH >= 5;
  // at DEPTH=4 the stream settles at four pairs every five cycles.
  assign occupancy = CW'(fifo_level) + CW'(s1_vld) + CW'(s2_vld) + CW'(s3_vld);
  assign in_ready  = run && (occupancy < DEP_CW);
  assign accept    = in_valid && in_ready;

  assign a_ext = {{W_IN{a[W_IN-1]}}, a};
  assign b_ext = {{W_IN{b[W_IN-1]}}, b};
  assign prod  = a_ext * b_ext;

  // Hold off acceptance until the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) run <= 1'b0;
    else       run <= 1'b1;
  end

  // S1: capture the full product together with its fractional-bit counts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_dat <= '{prod: prod, nfa: num_frac_a, nfb: num_frac_b, nfc: num_frac_c};
    end
  end

  assign sh_raw = {2'b00, s1_dat.nfa} + {2'b00, s1_dat.nfb} - {2'b00, s1_dat.nfc};
  assign sh_mag = -sh_raw;
  assign p_neg  = s1_dat.prod[PW-1];
  assign p_zero = (s1_dat.prod == '0);
  assign p_ext  = {{W_OUT{s1_dat.prod[PW-1]}}, s1_dat.prod};

  // Alignment: positive shift is a flooring right shift, negative a left shift;
  // unrepresentable left shifts are pinned to the wide extremes so S3 saturates them.
  always_comb begin
    aligned = p_ext;
    if (!sh_raw[9] && (sh_raw != '0)) begin
      if (sh_raw >= SH_RZ) aligned = p_neg ? '1 : '0;
      else                 aligned = p_ext >>> sh_raw;
    end else if (sh_raw[9]) begin
      if (p_zero)                 aligned = '0;
      else if (sh_mag >= SH_LOV)  aligned = p_neg ? WIDE_MIN : WIDE_MAX;
      else                        aligned = p_ext <<< sh_mag;
    end
  end

  // S2: register the aligned value at full width.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_vld <= 1'b0;
      s2_dat <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) s2_dat <= aligned;
    end
  end

  // Saturation into the signed result range.
  always_comb begin
    res_nxt.val = s2_dat[W_OUT-1:0];
    res_nxt.sat = 1'b0;
    if (s2_dat > OUT_MAX) begin
      res_nxt.val = {1'b0, {(W_OUT-1){1'b1}}};
      res_nxt.sat = 1'b1;
    end else if (s2_dat < OUT_MIN) begin
      res_nxt.val = {1'b1, {(W_OUT-1){1'b0}}};
      res_nxt.sat = 1'b1;
    end
  end

  // S3: register the final result; it is written to the FIFO on the following edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_vld <= 1'b0;
      s3_dat <= '0;
    end else begin
      s3_vld <= s2_vld;
      if (s2_vld) s3_dat <= res_nxt;
    end
  end

  qsc_fifo #(
    .W     ($bits(res_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .wr_vld (s3_vld),
    .wr_dat (s3_dat),
    .rd_vld (head_vld),
    .rd_rdy (out_ready),
    .rd_dat (head_dat),
    .level  (fifo_level)
  );

  // Outputs read zero whenever the FIFO is empty, including straight out of reset.
  assign out_valid = head_vld;
  assign c         = head_vld ? head_dat.val : '0;
  assign sat       = head_vld ? head_dat.sat : 1'b0;

  // Delivered-result counter, free-running modulo 2^16.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       out_count <= '0;
    else if (out_valid && out_ready) out_count <= out_count + 16'd1;
  end
endmodule

// File: tb/tb_quad_stream_core.sv
// Purpose: scoreboard bench for quad_stream_core at default parameters.
// Latency: checks the three-edge write latency directly, then streams through a queue model.
// Backpressure: drives random and forced in_valid/out_ready patterns, including full stalls and reset.

module tb_quad_stream_core;
  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] a;
  logic [13:0] b;
  logic [7:0]  num_frac_a;
  logic [7:0]  num_frac_b;
  logic [7:0]  num_frac_c;
  logic        out_valid;
  logic        out_ready;
  logic [28:0] c;
  logic        sat;
  logic [15:0] out_count;

  typedef struct {
    longint av;
    longint bv;
    int     fa;
    int     fb;
    int     fc;
    longint ec;
    bit     es;
  } item_t;

  typedef struct {
    longint ec;
    bit     es;
  } exp_t;

  item_t stim_q[$];
  exp_t  sb_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    accepted = 0;
  int    exp_count = 0;

  quad_stream_core dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .num_frac_a (num_frac_a),
    .num_frac_b (num_frac_b),
    .num_frac_c (num_frac_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .c          (c),
    .sat        (sat),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Reference: exact product, floor right shift, doubling loop for left shift, clamp to 29 bits.
  function automatic void model(input longint av, input longint bv, input int fa, input int fb,
                                input int fc, output longint ec, output bit es);
    longint p;
    longint v;
    int     sh;
    p  = av * bv;
    sh = fa + fb - fc;
    es = 1'b0;
    if (sh >= 0) begin
      if (sh >= 28) v = (p < 0) ? -1 : 0;
      else          v = p >>> sh;
    end else begin
      v = p;
      for (int i = 0; i < -sh; i++) begin
        if (v > 64'sd268435455 || v < -64'sd268435456) break;
        v = v * 2;
      end
    end
    if (v > 268435455) begin
      ec = 268435455;
      es = 1'b1;
    end else if (v < -268435456) begin
      ec = -268435456;
      es = 1'b1;
    end else begin
      ec = v;
    end
  endfunction

  task automatic add(input longint av, input longint bv, input int fa, input int fb, input int fc,
                     input longint ec, input bit es);
    item_t it;
    it.av = av; it.bv = bv; it.fa = fa; it.fb = fb; it.fc = fc; it.ec = ec; it.es = es;
    stim_q.push_back(it);
  endtask

  task automatic add_rand();
    logic [13:0] ra;
    logic [13:0] rb;
    longint      ec;
    bit          es;
    int          fa;
    int          fb;
    int          fc;
    ra = 14'($urandom);
    rb = 14'($urandom);
    fa = $urandom_range(0, 16);
    fb = $urandom_range(0, 16);
    fc = $urandom_range(0, 40);
    if ($urandom_range(15) == 0) fa = 255;
    if ($urandom_range(15) == 0) fc = 200;
    model(longint'($signed(ra)), longint'($signed(rb)), fa, fb, fc, ec, es);
    add(longint'($signed(ra)), longint'($signed(rb)), fa, fb, fc, ec, es);
  endtask

  // One clock: drive at the falling edge, then settle the handshakes the next rising edge will see.
  task automatic step(input logic iv, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid = iv && (stim_q.size() > 0);
    if (in_valid) begin
      a          = 14'(stim_q[0].av);
      b          = 14'(stim_q[0].bv);
      num_frac_a = 8'(stim_q[0].fa);
      num_frac_b = 8'(stim_q[0].fb);
      num_frac_c = 8'(stim_q[0].fc);
    end
    out_ready = ordy;
    #1;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        chk("spurious", 64'(out_valid), 64'd0);
      end else begin
        chk("c", 64'($signed(c)), sb_q[0].ec);
        chk("sat", 64'(sat), 64'(sb_q[0].es));
        if (out_ready) begin
          void'(sb_q.pop_front());
          exp_count++;
        end
      end
    end
    if (in_valid && in_ready) begin
      e.ec = stim_q[0].ec;
      e.es = stim_q[0].es;
      sb_q.push_back(e);
      void'(stim_q.pop_front());
      accepted++;
    end
    @(posedge clk);
  endtask

  task automatic drain(input int budget, input int pin, input int pout);
    int n;
    n = 0;
    while ((stim_q.size() > 0 || sb_q.size() > 0) && n < budget) begin
      step($urandom_range(99) < pin, $urandom_range(99) < pout);
      n++;
    end
    chk("drain_left", 64'(stim_q.size() + sb_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    rstn       = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    num_frac_a = '0;
    num_frac_b = '0;
    num_frac_c = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_c", 64'(c), 64'd0);
    chk("rst_sat", 64'(sat), 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);

    // Release away from the edge; in_ready rises only at the next rising edge.
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rel_in_ready0", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rel_in_ready1", 64'(in_ready), 64'd1);

    // Latency: 3*5 accepted at edge N shows up right after edge N+3.
    @(negedge clk);
    a = 14'd3; b = 14'd5; num_frac_a = 8'd0; num_frac_b = 8'd0; num_frac_c = 8'd0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("lat_rdy", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_n0", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_n1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_n2", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_n3", 64'(out_valid), 64'd1);
    chk("lat_c", 64'($signed(c)), 64'd15);
    chk("lat_sat", 64'(sat), 64'd0);
    chk("lat_cnt0", 64'(out_count), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    exp_count = 1;
    chk("lat_cnt1", 64'(out_count), 64'd1);
    chk("lat_empty", 64'(out_valid), 64'd0);

    // Directed arithmetic and shift/saturation boundaries.
    add(-8192, -8192, 0, 0, 0, 67108864, 1'b0);
    add(16, -16, 4, 4, 0, -1, 1'b0);
    add(8191, 8191, 0, 0, 8, 268435455, 1'b1);
    add(8191, -8191, 0, 0, 8, -268435456, 1'b1);
    add(-5, 3, 200, 100, 0, -1, 1'b0);
    add(5, 3, 200, 100, 0, 0, 1'b0);
    add(0, 1234, 0, 0, 255, 0, 1'b0);
    add(1, 1, 0, 0, 27, 134217728, 1'b0);
    add(1, 1, 0, 0, 28, 268435455, 1'b1);
    add(-1, 1, 0, 0, 28, -268435456, 1'b0);
    add(-1, 1, 0, 0, 29, -268435456, 1'b1);
    drain(200, 100, 100);

    // Full stall: offer ten pairs with the consumer stopped; only DEPTH fit.
    repeat (10) add_rand();
    acc0 = accepted;
    repeat (10) step(1'b1, 1'b0);
    chk("stall_acc", 64'(accepted - acc0), 64'd4);
    @(negedge clk);
    #1;
    chk("stall_rdy", 64'(in_ready), 64'd0);
    drain(200, 100, 100);

    // Reset with two results buffered and two still in the pipeline.
    repeat (4) add_rand();
    repeat (4) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("pre_rst_vld", 64'(out_valid), 64'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_rdy", 64'(in_ready), 64'd0);
    chk("mid_rst_vld", 64'(out_valid), 64'd0);
    chk("mid_rst_c", 64'(c), 64'd0);
    chk("mid_rst_sat", 64'(sat), 64'd0);
    chk("mid_rst_cnt", 64'(out_count), 64'd0);
    stim_q.delete();
    sb_q.delete();
    exp_count = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) step(1'b0, 1'b1);
    #1;
    chk("post_rst_vld", 64'(out_valid), 64'd0);
    add(-7, 9, 1, 0, 0, -32, 1'b0);
    drain(50, 100, 100);

    // Long random stream with random backpressure on both sides.
    repeat (1000) add_rand();
    drain(20000, 70, 70);
    @(negedge clk);
    #1;
    chk("out_count", 64'(out_count), 64'(16'(exp_count)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
